mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester (ibus/dbus) arbiter onto a single memory port with a BUSY timeout.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is fixed dbus priority.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ibus_address,
  input  logic [3:0]  ibus_byteenable,
  input  logic        ibus_read,
  input  logic        ibus_write,
  input  logic [31:0] ibus_wrdata,
  output logic [31:0] ibus_rddata,
  output logic        ibus_stall,
  input  logic [31:0] dbus_address,
  input  logic [3:0]  dbus_byteenable,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_wrdata,
  output logic [31:0] dbus_rddata,
  output logic        dbus_stall,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wrdata,
  input  logic [31:0] mem_rddata,
  input  logic        mem_ready,
  output logic        bus_error
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D} state_t;

  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_done_i, r_done_d, r_err, r_last_d;
  logic [31:0] r_i_rd, r_d_rd, r_addr, r_wd;
  logic [3:0]  r_be;
  logic        r_rd, r_wr;

  logic        w_req_i, w_req_d, w_elig_i, w_elig_d, w_pick_i, w_pick_d, w_busy_d;
  logic [15:0] w_cnt_nxt;

  assign w_req_i  = ibus_read | ibus_write;
  assign w_req_d  = dbus_read | dbus_write;
  // The port whose access just completed is still holding its old request this cycle.
  assign w_elig_i = w_req_i & ~r_done_i;
  assign w_elig_d = w_req_d & ~r_done_d;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_pick_d = w_elig_d & (~w_elig_i | ~r_last_d);
`else
  assign w_pick_d = w_elig_d;
`endif
  assign w_pick_i  = w_elig_i & ~w_pick_d;
  assign w_busy_d  = (r_state == S_BUSY_D);
  assign w_cnt_nxt = r_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done_i <= 1'b0;
      r_done_d <= 1'b0;
      r_err    <= 1'b0;
      r_last_d <= 1'b1;
      r_i_rd   <= '0;
      r_d_rd   <= '0;
      r_addr   <= '0;
      r_wd     <= '0;
      r_be     <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      r_done_i <= 1'b0;
      r_done_d <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_d) begin
            r_state  <= S_BUSY_D;
            r_addr   <= dbus_address;
            r_be     <= dbus_byteenable;
            r_wd     <= dbus_wrdata;
            r_wr     <= dbus_write;
            r_rd     <= dbus_read & ~dbus_write;
            r_cnt    <= '0;
            r_last_d <= 1'b1;
          end else if (w_pick_i) begin
            r_state  <= S_BUSY_I;
            r_addr   <= ibus_address;
            r_be     <= ibus_byteenable;
            r_wd     <= ibus_wrdata;
            r_wr     <= ibus_write;
            r_rd     <= ibus_read & ~ibus_write;
            r_cnt    <= '0;
            r_last_d <= 1'b0;
          end
        end
        default: begin
          // mem_ready takes precedence over a timeout landing in the same cycle.
          if (mem_ready) begin
            if (r_rd) begin
              if (w_busy_d) r_d_rd <= mem_rddata;
              else          r_i_rd <= mem_rddata;
            end
            r_done_d <= w_busy_d;
            r_done_i <= ~w_busy_d;
            r_state  <= S_IDLE;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
          end else if (w_cnt_nxt == TO_MAX) begin
            if (w_busy_d) r_d_rd <= '0;
            else          r_i_rd <= '0;
            r_done_d <= w_busy_d;
            r_done_i <= ~w_busy_d;
            r_err    <= 1'b1;
            r_cnt    <= w_cnt_nxt;
            r_state  <= S_IDLE;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
      endcase
    end
  end

  assign ibus_stall     = w_req_i & ~r_done_i;
  assign dbus_stall     = w_req_d & ~r_done_d;
  assign ibus_rddata    = r_i_rd;
  assign dbus_rddata    = r_d_rd;
  assign mem_address    = r_addr;
  assign mem_byteenable = r_be;
  assign mem_read       = r_rd;
  assign mem_write      = r_wr;
  assign mem_wrdata     = r_wd;
  assign bus_error      = r_err;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests push expected grants and
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ibus_address = '0, ibus_wrdata = '0, dbus_address = '0, dbus_wrdata = '0;
  logic [3:0]  ibus_byteenable = '0, dbus_byteenable = '0;
  logic        ibus_read = 1'b0, ibus_write = 1'b0, dbus_read = 1'b0, dbus_write = 1'b0;
  logic [31:0] ibus_rddata, dbus_rddata, mem_address, mem_wrdata;
  logic        ibus_stall, dbus_stall, mem_read, mem_write, bus_error;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_rddata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_address(ibus_address), .ibus_byteenable(ibus_byteenable), .ibus_read(ibus_read),
    .ibus_write(ibus_write), .ibus_wrdata(ibus_wrdata), .ibus_rddata(ibus_rddata),
    .ibus_stall(ibus_stall),
    .dbus_address(dbus_address), .dbus_byteenable(dbus_byteenable), .dbus_read(dbus_read),
    .dbus_write(dbus_write), .dbus_wrdata(dbus_wrdata), .dbus_rddata(dbus_rddata),
    .dbus_stall(dbus_stall),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata),
    .mem_ready(mem_ready), .bus_error(bus_error)
  );

  typedef struct packed {
    logic [31:0] a; logic [3:0] be; logic rd; logic wr; logic [31:0] wd;
  } gnt_t;
  typedef struct packed { logic [31:0] rd; logic err; } cmp_t;

  gnt_t gq[$];
  cmp_t iq[$], dq[$];
  int n_cmp = 0, n_bad = 0, n_err_pulse = 0;

  // Memory responder knobs
  bit          rsp_en = 1'b1, rsp_force = 1'b0;
  int          rsp_lat = 0;
  logic [31:0] rsp_data = '0;

  task automatic check(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Drive one request and hold it until the port unstalls; returns negedges waited.
  task automatic req(input bit d, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd, output int ncyc);
    @(posedge clk); #1;
    if (d) begin
      dbus_read = rd; dbus_write = wr; dbus_address = a; dbus_byteenable = be; dbus_wrdata = wd;
    end else begin
      ibus_read = rd; ibus_write = wr; ibus_address = a; ibus_byteenable = be; ibus_wrdata = wd;
    end
    ncyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ncyc++;
      if (d ? !dbus_stall : !ibus_stall) return;
    end
    bad(d ? "dbus_stall_timeout" : "ibus_stall_timeout");
  endtask

  task automatic idle(input bit d);
    @(posedge clk); #1;
    if (d) begin dbus_read = 1'b0; dbus_write = 1'b0; end
    else   begin ibus_read = 1'b0; ibus_write = 1'b0; end
  endtask

  // Responder: counts BUSY cycles and raises mem_ready in BUSY cycle rsp_lat+1.
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !(mem_read || mem_write)) busy_cnt = 0;
      else busy_cnt++;
      mem_ready  = rsp_force || (rsp_en && busy_cnt == rsp_lat + 1);
      mem_rddata = rsp_data;
    end
  end

  // Monitor
  initial begin
    gnt_t cur, prev_g;
    logic prev_stb, idn, ddn;
    prev_stb = 1'b0;
    prev_g   = '0;
    forever begin
      @(negedge clk);
      cur = {mem_address, mem_byteenable, mem_read, mem_write, mem_wrdata};
      if (mem_read || mem_write) begin
        if (prev_stb) check("mem_hold", cur, prev_g);
        else if (gq.size() == 0) bad("grant_unexpected");
        else check("grant", cur, gq.pop_front());
      end
      prev_stb = mem_read || mem_write;
      prev_g   = cur;
      idn = rst_n && (ibus_read || ibus_write) && !ibus_stall;
      ddn = rst_n && (dbus_read || dbus_write) && !dbus_stall;
      if (idn) begin
        if (iq.size() == 0) bad("ibus_done_unexpected");
        else check("ibus_done", {ibus_rddata, bus_error}, iq.pop_front());
      end
      if (ddn) begin
        if (dq.size() == 0) bad("dbus_done_unexpected");
        else check("dbus_done", {dbus_rddata, bus_error}, dq.pop_front());
      end
      if (bus_error) begin
        n_err_pulse++;
        if (!(idn || ddn)) bad("bus_error_without_done");
      end
    end
  end

  initial begin
    int nc, nci, ncd;
    // Reset state
    #12;
    check("rst_mem", {mem_address, mem_byteenable, mem_read, mem_write, mem_wrdata}, 70'h0);
    check("rst_rddata", {ibus_rddata, dbus_rddata}, 70'h0);
    check("rst_err_stall", {bus_error, ibus_stall, dbus_stall}, 70'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Single ibus read, minimum latency
    rsp_data = 32'hDEADBEEF;
    gq.push_back({32'h1000, 4'hF, 1'b1, 1'b0, 32'h0});
    iq.push_back({32'hDEADBEEF, 1'b0});
    req(1'b0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, nc);
    check("ibus_read_latency", nc, 3);
    idle(1'b0);

    // Simultaneous ibus read / dbus write: dbus first
    rsp_data = 32'h12345678;
    gq.push_back({32'h3000, 4'h3, 1'b0, 1'b1, 32'h55AA55AA});
    gq.push_back({32'h2000, 4'hF, 1'b1, 1'b0, 32'h0});
    dq.push_back({32'h0, 1'b0});
    iq.push_back({32'h12345678, 1'b0});
    fork
      begin req(1'b1, 1'b0, 1'b1, 32'h3000, 4'h3, 32'h55AA55AA, ncd); idle(1'b1); end
      begin req(1'b0, 1'b1, 1'b0, 32'h2000, 4'hF, 32'h0, nci); idle(1'b0); end
    join
    check("pair_dbus_latency", ncd, 3);
    check("pair_ibus_latency", nci, 5);

    // dbus read, then read+write treated as a write (rddata kept)
    rsp_data = 32'hA5A50F0F;
    gq.push_back({32'h4000, 4'hF, 1'b1, 1'b0, 32'h0});
    gq.push_back({32'h4004, 4'hC, 1'b0, 1'b1, 32'hCAFEF00D});
    dq.push_back({32'hA5A50F0F, 1'b0});
    dq.push_back({32'hA5A50F0F, 1'b0});
    req(1'b1, 1'b1, 1'b0, 32'h4000, 4'hF, 32'h0, nc);
    req(1'b1, 1'b1, 1'b1, 32'h4004, 4'hC, 32'hCAFEF00D, nc);
    idle(1'b1);

    // Both requesting continuously, last grant was dbus
    rsp_data = 32'h00C0FFEE;
`ifdef ARB_ROUND_ROBIN_EN
    gq.push_back({32'h5000, 4'hF, 1'b1, 1'b0, 32'h0});
    gq.push_back({32'h6000, 4'hF, 1'b0, 1'b1, 32'h11111111});
    gq.push_back({32'h5004, 4'hF, 1'b1, 1'b0, 32'h0});
    gq.push_back({32'h6004, 4'hF, 1'b0, 1'b1, 32'h22222222});
`else
    gq.push_back({32'h6000, 4'hF, 1'b0, 1'b1, 32'h11111111});
    gq.push_back({32'h5000, 4'hF, 1'b1, 1'b0, 32'h0});
    gq.push_back({32'h6004, 4'hF, 1'b0, 1'b1, 32'h22222222});
    gq.push_back({32'h5004, 4'hF, 1'b1, 1'b0, 32'h0});
`endif
    iq.push_back({32'h00C0FFEE, 1'b0});
    iq.push_back({32'h00C0FFEE, 1'b0});
    dq.push_back({32'hA5A50F0F, 1'b0});
    dq.push_back({32'hA5A50F0F, 1'b0});
    fork
      begin
        req(1'b1, 1'b0, 1'b1, 32'h6000, 4'hF, 32'h11111111, ncd);
        req(1'b1, 1'b0, 1'b1, 32'h6004, 4'hF, 32'h22222222, ncd);
        idle(1'b1);
      end
      begin
        req(1'b0, 1'b1, 1'b0, 32'h5000, 4'hF, 32'h0, nci);
        req(1'b0, 1'b1, 1'b0, 32'h5004, 4'hF, 32'h0, nci);
        idle(1'b0);
      end
    join

    // mem_ready on the same cycle the timeout count is reached: normal completion
    rsp_lat  = 3;
    rsp_data = 32'h77777777;
    gq.push_back({32'h7000, 4'hF, 1'b1, 1'b0, 32'h0});
    iq.push_back({32'h77777777, 1'b0});
    req(1'b0, 1'b1, 1'b0, 32'h7000, 4'hF, 32'h0, nc);
    check("ready_at_limit_latency", nc, 6);
    idle(1'b0);

    // Timeout abort
    rsp_en = 1'b0;
    rsp_lat = 0;
    gq.push_back({32'h8000, 4'hF, 1'b1, 1'b0, 32'h0});
    iq.push_back({32'h0, 1'b1});
    req(1'b0, 1'b1, 1'b0, 32'h8000, 4'hF, 32'h0, nc);
    check("timeout_latency", nc, 6);
    idle(1'b0);
    rsp_en = 1'b1;

    // mem_ready while idle is ignored
    rsp_data = 32'h99999999;
    @(posedge clk); #1 rsp_force = 1'b1;
    repeat (3) @(posedge clk);
    #1 rsp_force = 1'b0;
    @(negedge clk);
    check("idle_ready_ignored", {ibus_rddata, dbus_rddata, mem_read, mem_write}, {32'h0, 32'hA5A50F0F, 2'b00});

    // Reset mid BUSY_D: access dropped, reissued after release
    rsp_en = 1'b0;
    rsp_data = 32'h0;
    gq.push_back({32'h9000, 4'hF, 1'b0, 1'b1, 32'h9999AAAA});
    gq.push_back({32'h9000, 4'hF, 1'b0, 1'b1, 32'h9999AAAA});
    dq.push_back({32'h0, 1'b0});
    fork
      begin req(1'b1, 1'b0, 1'b1, 32'h9000, 4'hF, 32'h9999AAAA, ncd); idle(1'b1); end
      begin
        for (int k = 0; k < 20 && !mem_write; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_mem", {mem_address, mem_read, mem_write}, 70'h0);
        check("rst_mid_stall", {dbus_stall, bus_error, dbus_rddata}, {1'b1, 1'b0, 32'h0});
        @(negedge clk);
        check("rst_hold_stall", dbus_stall, 1'b1);
        #2 rst_n = 1'b1;
        rsp_en = 1'b1;
      end
    join

    repeat (4) @(negedge clk);
    check("grants_left", gq.size(), 0);
    check("done_left", iq.size() + dq.size(), 0);
    check("bus_error_pulses", n_err_pulse, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
